// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin arbiter/crossbar between the per-device transmit
//                FIFOs and the per-device receive FIFOs of the shared bus.
//                Pops one packet at a time from a pending source, decodes the
//                destination ID in its top byte, and pushes it into the
//                destination receive FIFO. A broadcast ID pushes it into every
//                receive FIFO except the sender's.
//  Ports       : clk     - clock, all logic on the rising edge
//                rst     - asynchronous, active-low reset
//                pndng   - per-source "FIFO non-empty" flags
//                D_pop   - per-source head words (first-word-fall-through)
//                pop     - per-source one-cycle pop strobes
//                full    - per-destination "receive FIFO full" flags
//                push    - per-destination one-cycle push strobes
//                D_push  - packet shared by all receive FIFOs, qualified by push
//                busy    - high while a packet is held for delivery
//                drop    - one-cycle pulse when the held packet is discarded
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter #(
    parameter int          WIDTH   = 16,
    parameter int          DEPTH   = 8,
    parameter int          DEVICES = 4,
    parameter logic [7:0]  BCAST   = 8'hFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DEVICES-1:0]         pndng,
    input  logic [DEVICES*WIDTH-1:0]   D_pop,
    output logic [DEVICES-1:0]         pop,
    input  logic [DEVICES-1:0]         full,
    output logic [DEVICES-1:0]         push,
    output logic [WIDTH-1:0]           D_push,
    output logic                       busy,
    output logic                       drop
);

    localparam int C_SRC_W = (DEVICES > 1) ? $clog2(DEVICES) : 1;

    // Arbitration is disabled for parameter sets the packet format cannot
    // support (device IDs must fit in the 8-bit destination field, and the
    // packet must be wide enough to carry that field).
    localparam bit C_PARAMS_OK = (DEVICES >= 2) && (DEVICES <= 255) &&
                                 (WIDTH >= 9) && (DEPTH >= 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_pkt;
    logic [C_SRC_W-1:0]     r_src;
    logic [C_SRC_W-1:0]     r_last;
    logic [DEVICES-1:0]     r_pop;
    logic [DEVICES-1:0]     r_push;
    logic [WIDTH-1:0]       r_dpush;
    logic                   r_busy;
    logic                   r_drop;

    // ------------------------------------------------------------------
    // Round-robin pick: the pending source with the smallest rotational
    // distance after the last granted index wins.
    // ------------------------------------------------------------------
    logic [C_SRC_W-1:0]     w_sel;
    logic                   w_found;
    int                     w_dist;
    int                     w_best;

    always_comb begin
        w_sel   = '0;
        w_dist  = 0;
        w_best  = DEVICES;
        for (int i = 0; i < DEVICES; i++) begin
            if (pndng[i]) begin
                w_dist = i - int'(r_last) - 1;
                if (w_dist < 0) begin
                    w_dist = w_dist + DEVICES;
                end
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    w_sel  = C_SRC_W'(i);
                end
            end
        end
        w_found = (|pndng) && C_PARAMS_OK;
    end

    // Head word and pop strobe of the selected source.
    logic [WIDTH-1:0]       w_head;
    logic [DEVICES-1:0]     w_sel_oh;

    always_comb begin
        w_head   = '0;
        w_sel_oh = '0;
        for (int i = 0; i < DEVICES; i++) begin
            if (C_SRC_W'(i) == w_sel) begin
                w_head      = D_pop[i*WIDTH +: WIDTH];
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Destination decode of the held packet.
    // ------------------------------------------------------------------
    logic [7:0]             w_dest;
    logic                   w_is_bcast;
    logic                   w_dest_ok;
    logic [DEVICES-1:0]     w_src_oh;
    logic [DEVICES-1:0]     w_dest_oh;
    logic [DEVICES-1:0]     w_targets;
    logic                   w_blocked;

    always_comb begin
        w_dest     = r_pkt[WIDTH-1 -: 8];
        w_is_bcast = (w_dest == BCAST);
        w_dest_ok  = (int'(w_dest) < DEVICES) && (w_dest != 8'(r_src));
        w_src_oh   = '0;
        w_dest_oh  = '0;
        for (int i = 0; i < DEVICES; i++) begin
            w_src_oh[i]  = (C_SRC_W'(i) == r_src);
            w_dest_oh[i] = (8'(i) == w_dest);
        end
        w_targets = w_is_bcast ? ~w_src_oh : w_dest_oh;
        // A broadcast is all-or-nothing, so any full target blocks it.
        w_blocked = |(w_targets & full);
    end

    // ------------------------------------------------------------------
    // Control FSM; every output is a register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pkt   <= '0;
            r_src   <= '0;
            r_last  <= C_SRC_W'(DEVICES - 1);
            r_pop   <= '0;
            r_push  <= '0;
            r_dpush <= '0;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_pop  <= '0;
            r_push <= '0;
            r_drop <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_pkt   <= w_head;
                        r_src   <= w_sel;
                        r_last  <= w_sel;
                        r_pop   <= w_sel_oh;
                        r_busy  <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_is_bcast || w_dest_ok) begin
                        // Hold the packet (head-of-line) until targets drain.
                        if (!w_blocked) begin
                            r_push  <= w_targets;
                            r_dpush <= r_pkt;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        // Self-addressed or unknown destination.
                        r_drop  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pop    = r_pop;
    assign push   = r_push;
    assign D_push = r_dpush;
    assign busy   = r_busy;
    assign drop   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter. Source FIFOs are small
//                circular buffers inside the bench; a packet-level model
//                predicts every output each cycle, and directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     pndng = '0;
    logic [N*W-1:0]   D_pop = '0;
    logic [N-1:0]     pop;
    logic [N-1:0]     full = '0;
    logic [N-1:0]     push;
    logic [W-1:0]     D_push;
    logic             busy;
    logic             drop;

    bus_arbiter #(
        .WIDTH   (W),
        .DEPTH   (8),
        .DEVICES (N),
        .BCAST   (8'hFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pndng   (pndng),
        .D_pop   (D_pop),
        .pop     (pop),
        .full    (full),
        .push    (push),
        .D_push  (D_push),
        .busy    (busy),
        .drop    (drop)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- source FIFOs ----------------
    logic [W-1:0] fmem [N][16];
    int           fwr  [N] = '{default: 0};
    int           frd  [N] = '{default: 0};

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            pndng[i]       = (fwr[i] != frd[i]);
            D_pop[i*W +: W] = fmem[i][frd[i] % 16];
        end
    endtask

    task automatic add(input int dev, input logic [W-1:0] p);
        fmem[dev][fwr[dev] % 16] = p;
        fwr[dev]++;
        refresh();
    endtask

    // ---------------- packet-level model ----------------
    bit           m_busy  = 1'b0;
    logic [W-1:0] m_pkt   = '0;
    int           m_src   = 0;
    int           m_last  = N - 1;
    logic [N-1:0] e_pop   = '0;
    logic [N-1:0] e_push  = '0;
    logic [W-1:0] e_dpush = '0;
    bit           e_busy  = 1'b0;
    bit           e_drop  = 1'b0;

    always @(posedge clk or negedge rst) begin : model
        int           pick;
        int           dest;
        int           idx;
        logic [N-1:0] tgt;
        if (!rst) begin
            m_busy  <= 1'b0;
            m_src   <= 0;
            m_last  <= N - 1;
            e_pop   <= '0;
            e_push  <= '0;
            e_dpush <= '0;
            e_busy  <= 1'b0;
            e_drop  <= 1'b0;
        end else begin
            e_pop  <= '0;
            e_push <= '0;
            e_drop <= 1'b0;
            if (!m_busy) begin
                pick = -1;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (pick < 0 && pndng[idx]) pick = idx;
                end
                if (pick >= 0) begin
                    m_pkt  <= D_pop[pick*W +: W];
                    m_src  <= pick;
                    m_last <= pick;
                    e_pop  <= N'(1 << pick);
                    m_busy <= 1'b1;
                    e_busy <= 1'b1;
                end
            end else begin
                dest = int'(m_pkt[W-1 -: 8]);
                if (dest == 255) begin
                    tgt = N'((1 << N) - 1) & ~N'(1 << m_src);
                    if ((tgt & full) == '0) begin
                        e_push  <= tgt;
                        e_dpush <= m_pkt;
                        m_busy  <= 1'b0;
                        e_busy  <= 1'b0;
                    end
                end else if (dest < N && dest != m_src) begin
                    if (!full[dest]) begin
                        e_push  <= N'(1 << dest);
                        e_dpush <= m_pkt;
                        m_busy  <= 1'b0;
                        e_busy  <= 1'b0;
                    end
                end else begin
                    e_drop <= 1'b1;
                    m_busy <= 1'b0;
                    e_busy <= 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare + FIFO pop + grant log ----------------
    bit cmp_en = 1'b0;
    int cyc    = 0;
    int glog [$];
    int gcyc [$];

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_pop",    pop,    e_pop);
            check("cyc_push",   push,   e_push);
            check("cyc_D_push", D_push, e_dpush);
            check("cyc_busy",   busy,   e_busy);
            check("cyc_drop",   drop,   e_drop);
        end
        for (int i = 0; i < N; i++) begin
            if (pop[i]) begin
                glog.push_back(i);
                gcyc.push_back(cyc);
            end
            if (e_pop[i]) frd[i]++;
        end
        refresh();
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pop(input logic [N-1:0] exp, input string name);
        int n = 0;
        while (pop == '0 && n < 20) begin
            tick();
            n++;
        end
        check(name, pop, exp);
    endtask

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin : stim
        int n;
        #2 rst = 1'b0;
        tick();
        check("rst_pop",    pop,    '0);
        check("rst_push",   push,   '0);
        check("rst_D_push", D_push, '0);
        check("rst_busy",   busy,   '0);
        check("rst_drop",   drop,   '0);
        cmp_en = 1'b1;
        tick();
        rst = 1'b1;

        // Unicast 1 -> 2
        add(1, 16'h02AB);
        wait_pop(4'b0010, "uni_pop");
        check("uni_busy", busy, 1);
        tick();
        check("uni_push",   push,   4'b0100);
        check("uni_D_push", D_push, 16'h02AB);
        check("uni_busy_clr", busy, 0);

        // Broadcast from 2, then stalled by full[0]
        add(2, 16'hFF55);
        wait_pop(4'b0100, "bc_pop");
        tick();
        check("bc_push",   push,   4'b1011);
        check("bc_D_push", D_push, 16'hFF55);
        full = 4'b0001;
        add(2, 16'hFF55);
        wait_pop(4'b0100, "bc2_pop");
        repeat (3) begin
            tick();
            check("bc_stall_push", push, 4'b0000);
            check("bc_stall_busy", busy, 1);
        end
        full = 4'b0000;
        tick();
        check("bc2_push",   push,   4'b1011);
        check("bc2_D_push", D_push, 16'hFF55);

        // Backpressure 0 -> 3
        full = 4'b1000;
        add(0, 16'h035A);
        wait_pop(4'b0001, "bp_pop");
        repeat (5) begin
            tick();
            check("bp_busy", busy, 1);
            check("bp_pop0", pop,  4'b0000);
            check("bp_push0", push, 4'b0000);
        end
        full = 4'b0000;
        tick();
        check("bp_push",   push,   4'b1000);
        check("bp_D_push", D_push, 16'h035A);

        // Drops: self destination, then out-of-range destination
        add(1, 16'h01C3);
        wait_pop(4'b0010, "drop_self_pop");
        tick();
        check("drop_self",      drop, 1);
        check("drop_self_push", push, 4'b0000);
        tick();
        check("drop_self_clr", drop, 0);
        add(0, 16'h0712);
        wait_pop(4'b0001, "drop_range_pop");
        tick();
        check("drop_range",      drop, 1);
        check("drop_range_push", push, 4'b0000);
        add(3, 16'h0099);
        wait_pop(4'b1000, "after_drop_pop");
        tick();
        check("after_drop_push",   push,   4'b0001);
        check("after_drop_D_push", D_push, 16'h0099);

        // Reset while a packet is held
        add(1, 16'h0211);
        wait_pop(4'b0010, "mid_pop");
        rst = 1'b0;
        #1;
        check("mid_rst_busy",   busy,   0);
        check("mid_rst_pop",    pop,    '0);
        check("mid_rst_push",   push,   '0);
        check("mid_rst_drop",   drop,   0);
        check("mid_rst_D_push", D_push, '0);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 2; k++) begin
                add(i, {8'((i + 1) % N), 8'(i * 16 + k)});
            end
        end
        tick();
        tick();
        glog.delete();
        gcyc.delete();
        rst = 1'b1;
        tick();
        check("rst_first_grant", pop, 4'b0001);

        // Round robin order and spacing
        n = 0;
        while (glog.size() < 5 && n < 40) begin
            tick();
            n++;
        end
        check("rr_count", (glog.size() >= 5), 1);
        if (glog.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("rr_order", glog[k], rr_exp[k]);
            for (int k = 0; k < 4; k++) check("rr_gap", gcyc[k+1] - gcyc[k], 2);
        end

        n = 0;
        while ((pndng != '0 || busy) && n < 100) begin
            tick();
            n++;
        end
        check("drain", {pndng, busy}, '0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
